ld3320_bus_ctrl: RTL

Parallel-bus master for the LD3320 speech-recognition chip, downstream of the LD3320 AXI4-Lite register slave. Converts one-register read/write requests into the chip's 8-bit A0/CS/WR/RD bus cycles, sequences chip reset, and synchronises the chip interrupt. All bus timing is in clock cycles, set by parameters.

---
 rtl/ld3320_pkg.sv | 31 +++
 rtl/ld3320_irq_sync.sv | 43 ++++
 rtl/ld3320_bus_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ld3320_pkg.sv
// Shared types and defaults for the LD3320 parallel-bus master.
package ld3320_pkg;

  localparam int LD_DW         = 8;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_HOLD_CYC  = 2;
  localparam int DEF_RST_CYC   = 1000;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_IDLE,
    ST_A_SETUP,
    ST_A_PULSE,
    ST_A_HOLD,
    ST_D_SETUP,
    ST_D_PULSE,
    ST_D_HOLD,
    ST_DONE
  } ld_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ld3320_irq_sync.sv
// Chip interrupt: 2-flop synchroniser, registered falling-edge detect, sticky flag.
module ld3320_irq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic intb_n,
  input  logic clr,
  output logic irq
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic fall_q, fall_d;
  logic irq_q, irq_d;

  always_comb begin
    sync1_d = intb_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fall_d  = prev_q & ~sync2_q;
    // A new edge takes priority over a simultaneous clear.
    irq_d   = fall_q ? 1'b1 : (clr ? 1'b0 : irq_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fall_q  <= fall_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/ld3320_bus_ctrl.sv
// LD3320 8-bit A0/CS/WR/RD bus master with chip-reset sequencing.
// Interrupt logic is compiled in only when LD3320_IRQ_EN is defined.
module ld3320_bus_ctrl
  import ld3320_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int RST_CYC   = DEF_RST_CYC
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [LD_DW-1:0] req_addr,
  input  logic [LD_DW-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [LD_DW-1:0] rsp_rdata,
  input  logic             rst_req,
  output logic             irq_o,
  input  logic             irq_clr,
  output logic             ld_cs_n,
  output logic             ld_wr_n,
  output logic             ld_rd_n,
  output logic             ld_a0,
  output logic [LD_DW-1:0] ld_data_o,
  input  logic [LD_DW-1:0] ld_data_i,
  output logic             ld_data_t,
  output logic             ld_rst_n,
  input  logic             ld_intb_n
);

  localparam int CNT_MAX = max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, RST_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [LD_DW-1:0] addr_q, addr_d;
  logic [LD_DW-1:0] wdata_q, wdata_d;
  logic [LD_DW-1:0] rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             rsp_q, rsp_d;
  logic             cs_n_q, cs_n_d;
  logic             wr_n_q, wr_n_d;
  logic             rd_n_q, rd_n_d;
  logic             a0_q, a0_d;
  logic [LD_DW-1:0] dout_q, dout_d;
  logic             dt_q, dt_d;
  logic             rst_n_q, rst_n_d;
  logic             in_a, in_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (rst_req) begin
          state_d = ST_RESET;
          cnt_d   = RST_LD;
        end else if (req_valid && ready_q) begin
          state_d = ST_A_SETUP;
          cnt_d   = SETUP_LD;
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          case (state_q)
            ST_RESET:   state_d = ST_IDLE;
            ST_A_SETUP: begin state_d = ST_A_PULSE; cnt_d = PULSE_LD; end
            ST_A_PULSE: begin state_d = ST_A_HOLD;  cnt_d = HOLD_LD;  end
            ST_A_HOLD:  begin state_d = ST_D_SETUP; cnt_d = SETUP_LD; end
            ST_D_SETUP: begin state_d = ST_D_PULSE; cnt_d = PULSE_LD; end
            ST_D_PULSE: begin
              state_d = ST_D_HOLD;
              cnt_d   = HOLD_LD;
              if (!wr_q) rdata_d = ld_data_i;
            end
            ST_D_HOLD:  state_d = ST_DONE;
            default:    state_d = ST_IDLE;
          endcase
        end
      end
    endcase

    // Chip outputs are decoded from the next state so they change on the same edge.
    in_a      = state_d inside {ST_A_SETUP, ST_A_PULSE, ST_A_HOLD};
    in_d      = state_d inside {ST_D_SETUP, ST_D_PULSE, ST_D_HOLD};
    ready_d   = (state_d == ST_IDLE);
    rsp_d     = (state_d == ST_DONE);
    rst_n_d   = (state_d != ST_RESET);
    cs_n_d    = !(in_a || in_d);
    a0_d      = in_a;
    wr_n_d    = !((state_d == ST_A_PULSE) || ((state_d == ST_D_PULSE) && wr_d));
    rd_n_d    = !((state_d == ST_D_PULSE) && !wr_d);
    dt_d      = in_a ? 1'b0 : (in_d ? !wr_d : 1'b1);
    dout_d    = in_a ? addr_d : ((in_d && wr_d) ? wdata_d : dout_q);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_RESET;
      cnt_q   <= RST_LD;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      rsp_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      a0_q    <= 1'b0;
      dout_q  <= '0;
      dt_q    <= 1'b1;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      a0_q    <= a0_d;
      dout_q  <= dout_d;
      dt_q    <= dt_d;
      rst_n_q <= rst_n_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign ld_cs_n   = cs_n_q;
  assign ld_wr_n   = wr_n_q;
  assign ld_rd_n   = rd_n_q;
  assign ld_a0     = a0_q;
  assign ld_data_o = dout_q;
  assign ld_data_t = dt_q;
  assign ld_rst_n  = rst_n_q;

`ifdef LD3320_IRQ_EN
  ld3320_irq_sync u_irq (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .intb_n (ld_intb_n),
    .clr    (irq_clr),
    .irq    (irq_o)
  );
`else
  logic unused_irq;
  assign unused_irq = irq_clr ^ ld_intb_n;
  assign irq_o      = 1'b0;
`endif

endmodule
